// File: rtl/senha_pkg.sv
// Purpose : shared types and constants for the keypad decoder and the lock controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a. Contents: senhaPac_t code word, digit markers, length bounds, FSM states.
package senha_pkg;

  localparam int NUM_DIGITOS = 20;

  // digits[0] is the most recently pressed key; unused positions hold DIGITO_VAZIO.
  typedef struct packed {
    logic [NUM_DIGITOS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] DIGITO_VAZIO   = 4'hF;
  localparam logic [3:0] DIGITO_CANCELA = 4'hB;
  localparam logic [3:0] DIGITO_TIMEOUT = 4'hE;

  localparam logic [4:0] TAM_MIN = 5'd4;
  localparam logic [4:0] TAM_MAX = 5'd12;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    VERIFICA = 3'd1,
    ABERTA   = 3'd2,
    SETUP    = 3'd3,
    GRAVA    = 3'd4,
    BLOQUEIO = 3'd5
  } estado_t;

endpackage

// File: rtl/classifica_senha.sv
// Purpose : classifies a captured code word as cancel, timeout, well-formed or malformed.
// Latency : purely combinational, zero cycles.
// Backpr. : none. Ports: senha (word in); cancela, timeout, bem_formada, tamanho[4:0] (out).
module classifica_senha
  import senha_pkg::*;
(
  input  senhaPac_t  senha,
  output logic       cancela,
  output logic       timeout,
  output logic       bem_formada,
  output logic [4:0] tamanho
);

  logic fim;   // first non-decimal digit has been reached
  logic lixo;  // something other than F was found after the decimal run

  always_comb begin
    cancela = 1'b1;
    timeout = 1'b1;
    tamanho = 5'd0;
    fim     = 1'b0;
    lixo    = 1'b0;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (senha.digits[i] != DIGITO_CANCELA) cancela = 1'b0;
      if (senha.digits[i] != DIGITO_TIMEOUT) timeout = 1'b0;
      // Length is the unbroken run of decimal digits starting at the newest key;
      // everything beyond that run has to be padding.
      if (!fim && (senha.digits[i] <= 4'd9)) begin
        tamanho = tamanho + 5'd1;
      end else begin
        fim = 1'b1;
        if (senha.digits[i] != DIGITO_VAZIO) lixo = 1'b1;
      end
    end
    bem_formada = !lixo && (tamanho >= TAM_MIN) && (tamanho <= TAM_MAX);
  end

endmodule

// File: rtl/controle_fechadura.sv
// Purpose : lock controller: checks keypad codes against master/user codes, opens, locks out, registers users.
// Latency : strobe at cycle t is checked at t+1; all outputs and slot writes update at t+2.
// Backpr. : teclado_enable low while open or locked out; strobes outside OCIOSO/SETUP are dropped.
// Ports   : clk, rst (sync, high); digitos_value/digitos_valid in; teclado_enable, tranca_aberta,
//           bloqueado, setup_ativo, erro, falhas out (all registered).
module controle_fechadura
  import senha_pkg::*;
#(
  parameter int        NUM_USERS   = 4,
  parameter senhaPac_t MASTER_CODE = 80'hFFFF_FFFF_FFFF_FFFF_1234,
  parameter int        MAX_FALHAS  = 3,
  parameter int        T_ABERTA    = 5000,
  parameter int        T_BLOQUEIO  = 20000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  senhaPac_t                       digitos_value,
  input  logic                            digitos_valid,
  output logic                            teclado_enable,
  output logic                            tranca_aberta,
  output logic                            bloqueado,
  output logic                            setup_ativo,
  output logic                            erro,
  output logic [$clog2(MAX_FALHAS+1)-1:0] falhas
);

  localparam int FW   = $clog2(MAX_FALHAS + 1);
  localparam int TMAX = (T_ABERTA > T_BLOQUEIO) ? T_ABERTA : T_BLOQUEIO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  estado_t        state_q, state_d;
  senhaPac_t      cap_q, cap_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [FW-1:0]  falhas_q, falhas_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           wr_en;

  senhaPac_t              slot_q [NUM_USERS];
  logic [NUM_USERS-1:0]   occ_q;

  logic en_q, en_d;
  logic tranca_q, tranca_d;
  logic bloq_q, bloq_d;
  logic setup_q, setup_d;
  logic erro_q, erro_d;

  logic       cancela, timeout, bem_formada;
  logic [4:0] tamanho;
  logic       valida;
  logic       match_user;

  classifica_senha u_classifica (
    .senha       (cap_q),
    .cancela     (cancela),
    .timeout     (timeout),
    .bem_formada (bem_formada),
    .tamanho     (tamanho)
  );

  // Length bounds repeated here so the accept condition reads in one place.
  assign valida = bem_formada && (tamanho >= TAM_MIN) && (tamanho <= TAM_MAX);

  // Empty slots are excluded by the occupied flag, not by their all-F contents.
  always_comb begin
    match_user = 1'b0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (occ_q[i] && (slot_q[i] == cap_q)) match_user = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    timer_d  = timer_q;
    falhas_d = falhas_q;
    ptr_d    = ptr_q;
    wr_en    = 1'b0;
    erro_d   = 1'b0;

    unique case (state_q)
      OCIOSO: begin
        if (digitos_valid) begin
          cap_d   = digitos_value;
          state_d = VERIFICA;
        end
      end

      VERIFICA: begin
        if (cancela || timeout) begin
          state_d = OCIOSO;
        end else if (valida && (cap_q == MASTER_CODE)) begin
          falhas_d = '0;
          state_d  = SETUP;
        end else if (valida && match_user) begin
          falhas_d = '0;
          timer_d  = TW'(T_ABERTA);
          state_d  = ABERTA;
        end else begin
          erro_d   = 1'b1;
          falhas_d = falhas_q + FW'(1);
          if (falhas_d == FW'(MAX_FALHAS)) begin
            timer_d = TW'(T_BLOQUEIO);
            state_d = BLOQUEIO;
          end else begin
            state_d = OCIOSO;
          end
        end
      end

      ABERTA: begin
        if (timer_q == TW'(1)) state_d = OCIOSO;
        else                   timer_d = timer_q - TW'(1);
      end

      SETUP: begin
        if (digitos_valid) begin
          cap_d   = digitos_value;
          state_d = GRAVA;
        end
      end

      GRAVA: begin
        state_d = OCIOSO;
        if (cancela || timeout) begin
          erro_d = 1'b0;
        end else if (valida && (cap_q != MASTER_CODE)) begin
          wr_en = 1'b1;
          ptr_d = (ptr_q == PW'(NUM_USERS - 1)) ? '0 : ptr_q + PW'(1);
        end else begin
          erro_d = 1'b1;
        end
      end

      BLOQUEIO: begin
        if (timer_q == TW'(1)) begin
          falhas_d = '0;
          state_d  = OCIOSO;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: state_d = OCIOSO;
    endcase

    // Outputs are registered from the next state so they line up with state entry.
    en_d     = !((state_d == ABERTA) || (state_d == BLOQUEIO));
    tranca_d = (state_d == ABERTA);
    bloq_d   = (state_d == BLOQUEIO);
    // Still waiting for the new code while it is being checked in GRAVA.
    setup_d  = (state_d == SETUP) || (state_d == GRAVA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OCIOSO;
      cap_q    <= '1;
      timer_q  <= '0;
      falhas_q <= '0;
      ptr_q    <= '0;
      en_q     <= 1'b1;
      tranca_q <= 1'b0;
      bloq_q   <= 1'b0;
      setup_q  <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      timer_q  <= timer_d;
      falhas_q <= falhas_d;
      ptr_q    <= ptr_d;
      en_q     <= en_d;
      tranca_q <= tranca_d;
      bloq_q   <= bloq_d;
      setup_q  <= setup_d;
      erro_q   <= erro_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) slot_q[i] <= '1;
      occ_q <= '0;
    end else if (wr_en) begin
      slot_q[ptr_q] <= cap_q;
      occ_q[ptr_q]  <= 1'b1;
    end
  end

  assign teclado_enable = en_q;
  assign tranca_aberta  = tranca_q;
  assign bloqueado      = bloq_q;
  assign setup_ativo    = setup_q;
  assign erro           = erro_q;
  assign falhas         = falhas_q;

endmodule
